// File: rtl/dag_pkg.sv
// dag_pkg: shared encodings for the dual data address generator.
// Register-type codes, generator-select codes and a register-address builder.
// The address layout is {type[1:0], dag, idx}.
package dag_pkg;

  // Register type codes (top two bits of a register address)
  localparam logic [1:0] DG_I = 2'b00;
  localparam logic [1:0] DG_M = 2'b01;
  localparam logic [1:0] DG_L = 2'b10;
  localparam logic [1:0] DG_B = 2'b11;

  // Generator select
  localparam logic DG_DM = 1'b0;
  localparam logic DG_PM = 1'b1;

  // Builds {typ, dag, idx} for an index field that is idx_w bits wide.
  function automatic int unsigned dg_reg_addr(input logic [1:0] typ, input logic dag,
                                              input int unsigned idx, input int unsigned idx_w);
    return (int'(typ) << (idx_w + 1)) | (int'(dag) << idx_w) | idx;
  endfunction

endpackage

// File: rtl/dag_mod_add.sv
// dag_mod_add: combinational circular adder producing the post-modify index.
// Ports: i, m, l, b (index, modify, length, base) in; nxt out.
// L = 0 gives a plain wrap-at-2^W add; otherwise the result stays in [B, B+L).
module dag_mod_add #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i,
  input  logic [ADDR_W-1:0] m,
  input  logic [ADDR_W-1:0] l,
  input  logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] nxt
);

  // Carry bits are kept so the upper-bound compare works at ADDR_W+1 bits.
  logic [ADDR_W:0] sum_w;
  logic [ADDR_W:0] top_w;
  logic [ADDR_W-1:0] sum;

  assign sum_w = {1'b0, i} + {1'b0, m};
  assign top_w = {1'b0, b} + {1'b0, l};
  assign sum   = sum_w[ADDR_W-1:0];

  always_comb begin
    nxt = sum;
    if (l != '0) begin
      if (!m[ADDR_W-1]) begin
        if (sum_w >= top_w) nxt = sum - l;
      end else begin
        // Negative modify: the truncated sum is the wrapped-back index.
        if (sum < b) nxt = sum + l;
      end
    end
  end

endmodule

// File: rtl/dag_circ_gen.sv
// dag_circ_gen: dual (DM/PM) data address generator with I/M/L/B banks.
// Inputs: ps_* request and register-access controls, bc_dt_out bus write data.
// Outputs: dg_bc_dt (combinational read), dg_dm_add/vld and dg_pm_add/vld (registered).
module dag_circ_gen
  import dag_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8,
  parameter int IDX_W  = $clog2(NREG),
  parameter int RA_W   = 3 + IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps_dg_en,
  input  logic              ps_dg_dgsclt,
  input  logic              ps_dg_mdfy,
  input  logic [IDX_W-1:0]  ps_dg_iadd,
  input  logic [IDX_W-1:0]  ps_dg_madd,
  input  logic              ps_dg_wrt_en,
  input  logic [RA_W-1:0]   ps_dg_wrt_add,
  input  logic [RA_W-1:0]   ps_dg_rd_add,
  input  logic [ADDR_W-1:0] bc_dt_out,
  output logic [ADDR_W-1:0] dg_bc_dt,
  output logic [ADDR_W-1:0] dg_dm_add,
  output logic              dg_dm_vld,
  output logic [ADDR_W-1:0] dg_pm_add,
  output logic              dg_pm_vld
);

  logic [ADDR_W-1:0] i_reg [2][NREG];
  logic [ADDR_W-1:0] m_reg [2][NREG];
  logic [ADDR_W-1:0] l_reg [2][NREG];
  logic [ADDR_W-1:0] b_reg [2][NREG];

  // Register-address field decode
  logic [1:0]       wr_typ, rd_typ;
  logic             wr_dag, rd_dag;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign wr_typ = ps_dg_wrt_add[RA_W-1 -: 2];
  assign wr_dag = ps_dg_wrt_add[IDX_W];
  assign wr_idx = ps_dg_wrt_add[IDX_W-1:0];
  assign rd_typ = ps_dg_rd_add[RA_W-1 -: 2];
  assign rd_dag = ps_dg_rd_add[IDX_W];
  assign rd_idx = ps_dg_rd_add[IDX_W-1:0];

  // Per-generator operands and results; the request reads pre-write values.
  logic [ADDR_W-1:0] cur_i [2];
  logic [ADDR_W-1:0] cur_m [2];
  logic [ADDR_W-1:0] nxt_i [2];
  logic [ADDR_W-1:0] req_add [2];

  for (genvar g = 0; g < 2; g++) begin : g_gen
    assign cur_i[g]   = i_reg[g][ps_dg_iadd];
    assign cur_m[g]   = m_reg[g][ps_dg_madd];
    assign req_add[g] = ps_dg_mdfy ? (cur_i[g] + cur_m[g]) : cur_i[g];

    dag_mod_add #(.ADDR_W(ADDR_W)) u_mod_add (
      .i   (cur_i[g]),
      .m   (cur_m[g]),
      .l   (l_reg[g][ps_dg_iadd]),
      .b   (b_reg[g][ps_dg_iadd]),
      .nxt (nxt_i[g])
    );
  end

  // Register banks: the bus write is issued after the modify update so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        for (int k = 0; k < NREG; k++) begin
          i_reg[g][k] <= '0;
          m_reg[g][k] <= '0;
          l_reg[g][k] <= '0;
          b_reg[g][k] <= '0;
        end
      end
    end else begin
      if (ps_dg_en && !ps_dg_mdfy)
        i_reg[ps_dg_dgsclt][ps_dg_iadd] <= nxt_i[ps_dg_dgsclt];
      if (ps_dg_wrt_en) begin
        case (wr_typ)
          DG_I: i_reg[wr_dag][wr_idx] <= bc_dt_out;
          DG_M: m_reg[wr_dag][wr_idx] <= bc_dt_out;
          DG_L: l_reg[wr_dag][wr_idx] <= bc_dt_out;
          default: begin
            // Loading a base also restarts the index at that base.
            b_reg[wr_dag][wr_idx] <= bc_dt_out;
            i_reg[wr_dag][wr_idx] <= bc_dt_out;
          end
        endcase
      end
    end
  end

  // Address outputs; the idle generator holds its address and drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dg_dm_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_pm_add <= '0;
      dg_pm_vld <= 1'b0;
    end else begin
      dg_dm_vld <= ps_dg_en && (ps_dg_dgsclt == DG_DM);
      dg_pm_vld <= ps_dg_en && (ps_dg_dgsclt == DG_PM);
      if (ps_dg_en && (ps_dg_dgsclt == DG_DM)) dg_dm_add <= req_add[0];
      if (ps_dg_en && (ps_dg_dgsclt == DG_PM)) dg_pm_add <= req_add[1];
    end
  end

  // Bus read with write bypass, including a B write seen through the matching I.
  always_comb begin
    case (rd_typ)
      DG_I:    dg_bc_dt = i_reg[rd_dag][rd_idx];
      DG_M:    dg_bc_dt = m_reg[rd_dag][rd_idx];
      DG_L:    dg_bc_dt = l_reg[rd_dag][rd_idx];
      default: dg_bc_dt = b_reg[rd_dag][rd_idx];
    endcase
    if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add))
      dg_bc_dt = bc_dt_out;
    else if (ps_dg_wrt_en && (wr_typ == DG_B) && (rd_typ == DG_I) &&
             (wr_dag == rd_dag) && (wr_idx == rd_idx))
      dg_bc_dt = bc_dt_out;
  end

endmodule

// File: tb/tb_dag_circ_gen.sv
// tb_dag_circ_gen: directed-vector bench for dag_circ_gen.
// Drives register writes and DM/PM requests, samples 1 time unit after each edge.
// Expected values are hand-computed constants.
module tb_dag_circ_gen;
  import dag_pkg::*;

  localparam int ADDR_W = 16;
  localparam int NREG   = 8;
  localparam int IDX_W  = 3;
  localparam int RA_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy, ps_dg_wrt_en;
  logic [IDX_W-1:0]  ps_dg_iadd, ps_dg_madd;
  logic [RA_W-1:0]   ps_dg_wrt_add, ps_dg_rd_add;
  logic [ADDR_W-1:0] bc_dt_out, dg_bc_dt, dg_dm_add, dg_pm_add;
  logic              dg_dm_vld, dg_pm_vld;

  int n_cmp = 0;
  int n_bad = 0;

  dag_circ_gen #(.ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
    .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
    .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
    .ps_dg_rd_add(ps_dg_rd_add), .bc_dt_out(bc_dt_out), .dg_bc_dt(dg_bc_dt),
    .dg_dm_add(dg_dm_add), .dg_dm_vld(dg_dm_vld),
    .dg_pm_add(dg_pm_add), .dg_pm_vld(dg_pm_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RA_W-1:0] ra(input logic [1:0] typ, input logic dag, input int idx);
    return RA_W'(dg_reg_addr(typ, dag, idx, IDX_W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [RA_W-1:0] a, input logic [15:0] d);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = a; bc_dt_out = d;
    tick();
    ps_dg_wrt_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [RA_W-1:0] a, input logic [15:0] exp);
    ps_dg_rd_add = a;
    #1;
    chk(tag, dg_bc_dt, exp);
  endtask

  task automatic req(input logic sel, input logic mdfy, input int ia, input int ma);
    ps_dg_en = 1'b1; ps_dg_dgsclt = sel; ps_dg_mdfy = mdfy;
    ps_dg_iadd = IDX_W'(ia); ps_dg_madd = IDX_W'(ma);
  endtask

  initial begin
    rst_n = 1'b0; ps_dg_en = 0; ps_dg_dgsclt = 0; ps_dg_mdfy = 0; ps_dg_iadd = 0;
    ps_dg_madd = 0; ps_dg_wrt_en = 0; ps_dg_wrt_add = 0; ps_dg_rd_add = 0; bc_dt_out = 0;
    #12;
    chk("rst_dm_add", dg_dm_add, 0);
    chk("rst_dm_vld", dg_dm_vld, 0);
    chk("rst_pm_add", dg_pm_add, 0);
    chk("rst_pm_vld", dg_pm_vld, 0);
    rd_chk("rst_i0", ra(DG_I, DG_DM, 0), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // DM post-modify, back to back
    wr(ra(DG_I, DG_DM, 0), 16'h0100);
    wr(ra(DG_M, DG_DM, 0), 16'h0004);
    req(DG_DM, 1'b0, 0, 0);
    chk("dm_vld_before", dg_dm_vld, 0);
    tick(); chk("pm1_a0", dg_dm_add, 16'h0100); chk("pm1_v0", dg_dm_vld, 1);
    chk("pm1_pmvld", dg_pm_vld, 0);
    tick(); chk("pm1_a1", dg_dm_add, 16'h0104);
    tick(); chk("pm1_a2", dg_dm_add, 16'h0108);
    ps_dg_en = 1'b0;
    tick(); chk("idle_vld", dg_dm_vld, 0); chk("idle_hold", dg_dm_add, 16'h0108);
    rd_chk("i0_after", ra(DG_I, DG_DM, 0), 16'h010C);

    // PM circular buffer, positive modify
    ps_dg_rd_add = ra(DG_I, DG_PM, 1);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(DG_B, DG_PM, 1); bc_dt_out = 16'h0200;
    #1; chk("b_bypass_i", dg_bc_dt, 16'h0200);
    tick(); ps_dg_wrt_en = 1'b0;
    rd_chk("i1_from_b", ra(DG_I, DG_PM, 1), 16'h0200);
    wr(ra(DG_L, DG_PM, 1), 16'd8);
    wr(ra(DG_M, DG_PM, 1), 16'd3);
    req(DG_PM, 1'b0, 1, 1);
    tick(); chk("circ_a0", dg_pm_add, 16'h0200); chk("circ_dmvld", dg_dm_vld, 0);
    tick(); chk("circ_a1", dg_pm_add, 16'h0203);
    tick(); chk("circ_a2", dg_pm_add, 16'h0206);
    tick(); chk("circ_a3", dg_pm_add, 16'h0201);
    chk("dm_hold", dg_dm_add, 16'h0108);
    ps_dg_en = 1'b0;

    // Negative modify wraps upward
    wr(ra(DG_M, DG_PM, 1), 16'hFFFD);
    wr(ra(DG_I, DG_PM, 1), 16'h0201);
    req(DG_PM, 1'b0, 1, 1);
    tick(); chk("neg_a0", dg_pm_add, 16'h0201);
    tick(); chk("neg_a1", dg_pm_add, 16'h0206);
    ps_dg_en = 1'b0;

    // Pre-modify leaves I untouched
    wr(ra(DG_I, DG_DM, 2), 16'h0010);
    wr(ra(DG_M, DG_DM, 2), 16'h0005);
    req(DG_DM, 1'b1, 2, 2);
    tick(); chk("pre_add", dg_dm_add, 16'h0015);
    ps_dg_en = 1'b0;
    rd_chk("pre_i2", ra(DG_I, DG_DM, 2), 16'h0010);

    // Bus write to I0 collides with post-modify of I0
    req(DG_DM, 1'b0, 0, 0);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(DG_I, DG_DM, 0); bc_dt_out = 16'h0500;
    ps_dg_rd_add = ra(DG_I, DG_DM, 0);
    #1; chk("col_bypass", dg_bc_dt, 16'h0500);
    tick(); ps_dg_wrt_en = 1'b0; ps_dg_en = 1'b0;
    chk("col_addr", dg_dm_add, 16'h010C);
    rd_chk("col_i0", ra(DG_I, DG_DM, 0), 16'h0500);

    // Bus write to M0 during a pre-modify: old M0 is used
    req(DG_DM, 1'b1, 0, 0);
    ps_dg_wrt_en = 1'b1; ps_dg_wrt_add = ra(DG_M, DG_DM, 0); bc_dt_out = 16'h0008;
    tick(); ps_dg_wrt_en = 1'b0; ps_dg_en = 1'b0;
    chk("mcol_addr", dg_dm_add, 16'h0504);
    rd_chk("mcol_m0", ra(DG_M, DG_DM, 0), 16'h0008);

    // Asynchronous reset mid-request
    req(DG_PM, 1'b0, 1, 1);
    tick(); chk("pre_rst_vld", dg_pm_vld, 1);
    #2; rst_n = 1'b0; #1;
    chk("arst_pm_vld", dg_pm_vld, 0);
    chk("arst_pm_add", dg_pm_add, 0);
    chk("arst_dm_add", dg_dm_add, 0);
    ps_dg_en = 1'b0;
    rd_chk("arst_i0", ra(DG_I, DG_DM, 0), 0);
    rd_chk("arst_m0", ra(DG_M, DG_DM, 0), 0);
    rd_chk("arst_l1", ra(DG_L, DG_PM, 1), 0);
    rd_chk("arst_b1", ra(DG_B, DG_PM, 1), 0);
    rd_chk("arst_i2", ra(DG_I, DG_DM, 2), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dag_circ_gen.md
# dag_circ_gen

Parametrised dual data address generator (DAG) for the processor core: one generator drives data-memory addresses, the other drives program-memory addresses. Each generator has index (I), modify (M), length (L) and base (B) register banks. It supports pre-modify and post-modify addressing, with modulo (circular-buffer) wrap on post-modify. The block sits between the program sequencer (`ps_*` controls) and the universal register bus (`bc_dt_out` in, `dg_bc_dt` out). Address outputs are registered.

## Interface
Parameters:
- `ADDR_W`, 16: width of addresses and of every I/M/L/B register.
- `NREG`, 8: registers per bank per DAG; must be a power of 2; `IDX_W = log2(NREG)`.
- `RA_W`, `3+IDX_W` (derived): register-address width, encoded as `{type[1:0], dag, idx}`.
  - type 00 = I, 01 = M, 10 = L, 11 = B.
  - dag 0 = DM generator, 1 = PM generator.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `ps_dg_en`, in, 1: address request this cycle.
- `ps_dg_dgsclt`, in, 1: generator select, 0 = DM, 1 = PM.
- `ps_dg_mdfy`, in, 1: 1 = pre-modify, no update; 0 = post-modify, with update.
- `ps_dg_iadd`, in, IDX_W: index register number.
- `ps_dg_madd`, in, IDX_W: modify register number.
- `ps_dg_wrt_en`, in, 1: register write strobe.
- `ps_dg_wrt_add`, in, RA_W: register write address.
- `ps_dg_rd_add`, in, RA_W: register read address.
- `bc_dt_out`, in, ADDR_W: write data from the bus.
- `dg_bc_dt`, out, ADDR_W: read data to the bus; combinational.
- `dg_dm_add`, out, ADDR_W: DM address; registered.
- `dg_dm_vld`, out, 1: `dg_dm_add` valid.
- `dg_pm_add`, out, ADDR_W: PM address; registered.
- `dg_pm_vld`, out, 1: `dg_pm_add` valid.

## Operation
- Reset state:
  - All I, M, L and B registers are 0.
  - `dg_dm_add` and `dg_pm_add` are 0.
  - Both valid flags are 0.
- Request: when `ps_dg_en` is 1, the selected generator uses `I = I[iadd]`, `M = M[madd]`, `L = L[iadd]`, `B = B[iadd]`.
  - Pre-modify (`mdfy` = 1): address = `I + M` (mod 2^ADDR_W). No register changes.
  - Post-modify (`mdfy` = 0): address = `I`. Then `I[iadd]` is updated with `next = I + M`.
- Modulo wrap, applied only when L ≠ 0. M is treated as two's complement.
  - M ≥ 0 and `next ≥ B + L`: `next -= L`.
  - M < 0 and `next < B`: `next += L`.
  - All sums are computed at ADDR_W+1 bits, then truncated.
  - L = 0: plain linear add with wrap at 2^ADDR_W.
- Register writes (`wrt_en` = 1): the addressed register takes `bc_dt_out`.
  - A write to B[n] also writes I[n] with the same value, in the same cycle.
- Same-cycle collisions:
  - A bus write to the I register being post-modified wins; the modify update is discarded.
  - A bus write to M, L or B while a request uses that register: the request uses the old value.
- Read: `dg_bc_dt` = register at `rd_add`.
  - Bypass: when `wrt_en` is 1 and `wrt_add == rd_add`, `dg_bc_dt = bc_dt_out`.
  - For a B write, a same-cycle read of the matching I register also bypasses.
- The generator not selected holds its output and drives its valid flag to 0.

## Timing
- Address latency is one cycle: the request in cycle N gives `*_add`/`*_vld` after edge N+1.
- Back-to-back post-modify requests on the same I see the updated value in the next cycle; no stall.
- `ps_dg_en` = 0: both valid flags go to 0 next cycle; address outputs hold.
- Reset is asserted asynchronously; deassertion is synchronised externally. A request in flight during reset is dropped.

## Structure
- Package `dag_pkg` holds:
  - the register-type encoding constants (`DG_I`, `DG_M`, `DG_L`, `DG_B`);
  - the DAG-select constants;
  - a function that builds a register address.
- Sub-module `dag_mod_add`: combinational circular adder (I, M, L, B → next). It is instanced once per generator.

## Test plan
- Reset, then write I0 = 0x0100 and M0 = 0x0004, DM post-modify ×3 → addresses 0x0100, 0x0104, 0x0108, each one cycle after request; I0 = 0x010C.
- Write B1 = 0x0200 (I1 becomes 0x0200), L1 = 8, M1 = 3, PM post-modify ×4 → addresses 0x200, 0x203, 0x206, 0x201.
- Set M1 = 0xFFFD (−3), I1 = 0x0201 → addresses 0x201, 0x206.
- Pre-modify with I2 = 0x0010, M2 = 5 → address 0x0015; I2 unchanged on readback.
- Same-cycle bus write I0 = 0x0500 and post-modify on I0 → address is the old I0; I0 = 0x0500 afterwards. Read of I0 in the write cycle returns 0x0500 via bypass.
- Assert `rst_n` low mid-sequence → valid flags and outputs go to 0 immediately; all registers read back 0.
